// File: rtl/pipe_detect_ctrl.sv
// Upstream-port Detect sub-state controller (Detect.Quiet -> Detect.Active -> exit) for a Gen1 x1 PIPE link.
// Optional macro DETECT_EIDLE_EXIT_EN: leave Detect.Quiet early when RxElecIdle is sampled low.
module pipe_detect_ctrl #(
    parameter int QUIET_TMO = 1200000,
    parameter int PHY_TMO   = 64
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       PhyStatus,
    input  logic [2:0] RxStatus,
    input  logic       RxElecIdle,
    output logic       TxDetectRxorLpbk,
    output logic       TxElecIdle,
    output logic [2:0] PowerDown,
    output logic [2:0] det_state,
    output logic       detect_done,
    output logic       rx_detected
);
    localparam int QW = $clog2(QUIET_TMO);
    localparam int PW = $clog2(PHY_TMO);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_TMO - 1);
    localparam logic [PW-1:0] PHY_LAST   = PW'(PHY_TMO - 1);
    localparam logic [2:0]    RX_FOUND   = 3'b011;
    localparam logic [2:0]    P1         = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        QUIET  = 3'd1,
        ACTIVE = 3'd2,
        EXIT   = 3'd3
    } detSub_t;

    detSub_t         state;
    detSub_t         stateNxt;
    logic [QW-1:0]   quietTmr;
    logic [QW-1:0]   quietTmrNxt;
    logic [PW-1:0]   phyTmr;
    logic [PW-1:0]   phyTmrNxt;
    logic            txDetNxt;
    logic            doneNxt;
    logic            rxDetNxt;
    logic            eidleExit;

`ifdef DETECT_EIDLE_EXIT_EN
    assign eidleExit = !RxElecIdle;
`else
    logic unusedRxElecIdle;
    assign unusedRxElecIdle = RxElecIdle;
    assign eidleExit        = 1'b0;
`endif

    assign det_state = state;

    // State, timer and output registers
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state            <= IDLE;
            quietTmr         <= '0;
            phyTmr           <= '0;
            TxDetectRxorLpbk <= 1'b0;
            TxElecIdle       <= 1'b1;
            PowerDown        <= P1;
            detect_done      <= 1'b0;
            rx_detected      <= 1'b0;
        end else begin
            state            <= stateNxt;
            quietTmr         <= quietTmrNxt;
            phyTmr           <= phyTmrNxt;
            TxDetectRxorLpbk <= txDetNxt;
            TxElecIdle       <= 1'b1;
            PowerDown        <= P1;
            detect_done      <= doneNxt;
            rx_detected      <= rxDetNxt;
        end
    end

    // Abort outranks PhyStatus, which outranks the PHY timeout
    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: begin
                if (start) stateNxt = QUIET;
            end
            QUIET: begin
                if (!start)                                  stateNxt = IDLE;
                else if (quietTmr == QUIET_LAST || eidleExit) stateNxt = ACTIVE;
            end
            ACTIVE: begin
                if (!start)                  stateNxt = IDLE;
                else if (PhyStatus)          stateNxt = (RxStatus == RX_FOUND) ? EXIT : QUIET;
                else if (phyTmr == PHY_LAST) stateNxt = QUIET;
            end
            EXIT:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Timers sit at zero outside their own sub-state, so entry always starts a fresh count
    always_comb begin
        quietTmrNxt = '0;
        phyTmrNxt   = '0;
        if (state == QUIET)
            quietTmrNxt = (quietTmr == QUIET_LAST) ? quietTmr : quietTmr + 1'b1;
        if (state == ACTIVE)
            phyTmrNxt = (phyTmr == PHY_LAST) ? phyTmr : phyTmr + 1'b1;

        txDetNxt = (stateNxt == ACTIVE);
        doneNxt  = (stateNxt == EXIT);

        rxDetNxt = rx_detected;
        if (state == IDLE && stateNxt == QUIET)
            rxDetNxt = 1'b0;
        else if (state == ACTIVE && stateNxt == EXIT)
            rxDetNxt = 1'b1;
    end

endmodule

// File: tb/tb_pipe_detect_ctrl.sv
// Self-checking bench for pipe_detect_ctrl: directed scenarios plus randomized traffic against a cycle-level model.
// Honours DETECT_EIDLE_EXIT_EN when the design is built with it.
module tb_pipe_detect_ctrl;
    localparam int QUIET_TMO = 16;
    localparam int PHY_TMO   = 8;

    logic       pclk = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic       phyStatus = 1'b0;
    logic [2:0] rxStatus = 3'b000;
    logic       rxElecIdle = 1'b1;
    logic       txDet;
    logic       txEidle;
    logic [2:0] powerDown;
    logic [2:0] detState;
    logic       detectDone;
    logic       rxDetected;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: sub-state, cycles already spent in it, and expected registered outputs
    int mSt = 0;
    int mCnt = 0;
    bit mTx = 0;
    bit mDone = 0;
    bit mRx = 0;

    pipe_detect_ctrl #(.QUIET_TMO(QUIET_TMO), .PHY_TMO(PHY_TMO)) dut (
        .pclk(pclk),
        .reset_n(resetN),
        .start(start),
        .PhyStatus(phyStatus),
        .RxStatus(rxStatus),
        .RxElecIdle(rxElecIdle),
        .TxDetectRxorLpbk(txDet),
        .TxElecIdle(txEidle),
        .PowerDown(powerDown),
        .det_state(detState),
        .detect_done(detectDone),
        .rx_detected(rxDetected)
    );

    always #5 pclk = ~pclk;

    task automatic modelStep();
        int ns;
        bit eidle;
`ifdef DETECT_EIDLE_EXIT_EN
        eidle = !rxElecIdle;
`else
        eidle = 1'b0;
`endif
        if (!resetN) begin
            mSt = 0; mCnt = 0; mTx = 0; mDone = 0; mRx = 0;
            return;
        end
        ns = mSt;
        case (mSt)
            0: if (start) ns = 1;
            1: if (!start) ns = 0; else if (mCnt + 1 >= QUIET_TMO || eidle) ns = 2;
            2: if (!start) ns = 0;
               else if (phyStatus) ns = (rxStatus == 3'b011) ? 3 : 1;
               else if (mCnt + 1 >= PHY_TMO) ns = 1;
            default: ns = 0;
        endcase
        if (mSt == 0 && ns == 1) mRx = 0;
        if (mSt == 2 && ns == 3) mRx = 1;
        mCnt  = (ns == mSt) ? mCnt + 1 : 0;
        mTx   = (ns == 2);
        mDone = (ns == 3);
        mSt   = ns;
    endtask

    task automatic tick();
        @(posedge pclk);
        modelStep();
        #1;
    endtask

    task automatic runToActive();
        start = 1'b1;
        tick();
        repeat (QUIET_TMO) tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0; start = 1'b0;
        tick(); tick();
        resetN = 1'b1;
        nCompared++; if (detState !== 3'd0) begin nMismatched++; $display("FAIL reset_det_state: got %0d want 0", detState); end
        nCompared++; if (txDet !== 1'b0) begin nMismatched++; $display("FAIL reset_txdet: got %b want 0", txDet); end
        nCompared++; if (txEidle !== 1'b1) begin nMismatched++; $display("FAIL reset_txeidle: got %b want 1", txEidle); end
        nCompared++; if (powerDown !== 3'b010) begin nMismatched++; $display("FAIL reset_powerdown: got %b want 010", powerDown); end
        nCompared++; if (detectDone !== 1'b0) begin nMismatched++; $display("FAIL reset_done: got %b want 0", detectDone); end
        nCompared++; if (rxDetected !== 1'b0) begin nMismatched++; $display("FAIL reset_rxdet: got %b want 0", rxDetected); end
    endtask

    task automatic test_success();
        bit quietOk = 1;
        start = 1'b1;
        tick();
        nCompared++; if (detState !== 3'd1) begin nMismatched++; $display("FAIL success_enter_quiet: got %0d want 1", detState); end
        for (int i = 0; i < QUIET_TMO - 1; i++) begin
            tick();
            if (detState !== 3'd1 || txDet !== 1'b0) quietOk = 0;
        end
        nCompared++; if (!quietOk) begin nMismatched++; $display("FAIL success_quiet_dwell: left quiet early, state=%0d want 1", detState); end
        tick();
        nCompared++; if (detState !== 3'd2) begin nMismatched++; $display("FAIL success_active: got %0d want 2", detState); end
        nCompared++; if (txDet !== 1'b1) begin nMismatched++; $display("FAIL success_txdet_rise: got %b want 1", txDet); end
        tick(); tick();
        phyStatus = 1'b1; rxStatus = 3'b011;
        tick();
        phyStatus = 1'b0; rxStatus = 3'b000;
        nCompared++; if (detState !== 3'd3) begin nMismatched++; $display("FAIL success_exit: got %0d want 3", detState); end
        nCompared++; if (detectDone !== 1'b1) begin nMismatched++; $display("FAIL success_done_pulse: got %b want 1", detectDone); end
        nCompared++; if (txDet !== 1'b0) begin nMismatched++; $display("FAIL success_txdet_fall: got %b want 0", txDet); end
        nCompared++; if (rxDetected !== 1'b1) begin nMismatched++; $display("FAIL success_rxdet: got %b want 1", rxDetected); end
        start = 1'b0;
        tick();
        nCompared++; if (detState !== 3'd0) begin nMismatched++; $display("FAIL success_back_idle: got %0d want 0", detState); end
        nCompared++; if (detectDone !== 1'b0) begin nMismatched++; $display("FAIL success_done_width: got %b want 0", detectDone); end
        nCompared++; if (rxDetected !== 1'b1) begin nMismatched++; $display("FAIL success_rxdet_sticky: got %b want 1", rxDetected); end
    endtask

    task automatic test_not_detected();
        int quietCnt = 1;
        bit sawDone = 0;
        bit reasserted = 0;
        runToActive();
        tick(); tick();
        phyStatus = 1'b1; rxStatus = 3'b000;
        tick();
        phyStatus = 1'b0;
        nCompared++; if (detState !== 3'd1) begin nMismatched++; $display("FAIL notdet_requiet: got %0d want 1", detState); end
        nCompared++; if (txDet !== 1'b0) begin nMismatched++; $display("FAIL notdet_txdet_fall: got %b want 0", txDet); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (detectDone) sawDone = 1;
            if (txDet) begin reasserted = 1; break; end
            if (detState == 3'd1) quietCnt++;
        end
        nCompared++; if (!reasserted) begin nMismatched++; $display("FAIL notdet_reassert: txdet=%b want 1 within 40 cycles", txDet); end
        nCompared++; if (quietCnt != QUIET_TMO) begin nMismatched++; $display("FAIL notdet_quiet_len: got %0d want %0d", quietCnt, QUIET_TMO); end
        nCompared++; if (sawDone) begin nMismatched++; $display("FAIL notdet_no_done: got 1 want 0"); end
        nCompared++; if (rxDetected !== 1'b0) begin nMismatched++; $display("FAIL notdet_rxdet: got %b want 0", rxDetected); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_phy_silent();
        int txCnt = 0;
        runToActive();
        if (txDet) txCnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (txDet) txCnt++; else break;
        end
        nCompared++; if (txCnt != PHY_TMO) begin nMismatched++; $display("FAIL silent_tx_len: got %0d want %0d", txCnt, PHY_TMO); end
        nCompared++; if (detState !== 3'd1) begin nMismatched++; $display("FAIL silent_requiet: got %0d want 1", detState); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        runToActive();
        tick(); tick();
        start = 1'b0; phyStatus = 1'b1; rxStatus = 3'b011;
        tick();
        phyStatus = 1'b0; rxStatus = 3'b000;
        nCompared++; if (detState !== 3'd0) begin nMismatched++; $display("FAIL abort_idle: got %0d want 0", detState); end
        nCompared++; if (detectDone !== 1'b0) begin nMismatched++; $display("FAIL abort_no_done: got %b want 0", detectDone); end
        nCompared++; if (rxDetected !== 1'b0) begin nMismatched++; $display("FAIL abort_rxdet: got %b want 0", rxDetected); end
        nCompared++; if (txDet !== 1'b0) begin nMismatched++; $display("FAIL abort_txdet: got %b want 0", txDet); end
        tick();
        nCompared++; if (detectDone !== 1'b0) begin nMismatched++; $display("FAIL abort_no_late_done: got %b want 0", detectDone); end
    endtask

    task automatic test_reset_mid();
        runToActive();
        nCompared++; if (txDet !== 1'b1) begin nMismatched++; $display("FAIL rstmid_pre_txdet: got %b want 1", txDet); end
        resetN = 1'b0;
        tick();
        nCompared++; if (detState !== 3'd0) begin nMismatched++; $display("FAIL rstmid_det_state: got %0d want 0", detState); end
        nCompared++; if (txDet !== 1'b0) begin nMismatched++; $display("FAIL rstmid_txdet: got %b want 0", txDet); end
        nCompared++; if (txEidle !== 1'b1) begin nMismatched++; $display("FAIL rstmid_txeidle: got %b want 1", txEidle); end
        nCompared++; if (powerDown !== 3'b010) begin nMismatched++; $display("FAIL rstmid_powerdown: got %b want 010", powerDown); end
        resetN = 1'b1; start = 1'b0;
        tick();
        nCompared++; if (detState !== 3'd0) begin nMismatched++; $display("FAIL rstmid_stays_idle: got %0d want 0", detState); end
    endtask

    task automatic test_early_exit();
        int quietCnt;
        start = 1'b1; rxElecIdle = 1'b1;
        tick();
        repeat (4) tick();
        rxElecIdle = 1'b0;
        tick();
        rxElecIdle = 1'b1;
        quietCnt = 5;
`ifdef DETECT_EIDLE_EXIT_EN
        nCompared++; if (detState !== 3'd2) begin nMismatched++; $display("FAIL early_exit_active: got %0d want 2", detState); end
        nCompared++; if (txDet !== 1'b1) begin nMismatched++; $display("FAIL early_exit_txdet: got %b want 1", txDet); end
`else
        nCompared++; if (detState !== 3'd1) begin nMismatched++; $display("FAIL eidle_ignored: got %0d want 1", detState); end
        for (int i = 0; i < 40 && detState == 3'd1; i++) begin
            quietCnt++;
            tick();
        end
        nCompared++; if (quietCnt != QUIET_TMO || detState !== 3'd2) begin
            nMismatched++; $display("FAIL eidle_full_quiet: quiet=%0d state=%0d want %0d then 2", quietCnt, detState, QUIET_TMO);
        end
`endif
        start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 4000; c++) begin
            resetN = ($urandom_range(0, 299) != 0);
            if (start) start = ($urandom_range(0, 99) >= 2);
            else       start = ($urandom_range(0, 99) < 25);
            phyStatus  = ($urandom_range(0, 99) < 12);
            rxStatus   = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'($urandom_range(0, 7));
            rxElecIdle = ($urandom_range(0, 99) >= 8);
            tick();
            nCompared++;
            if (detState !== 3'(mSt) || txDet !== mTx || detectDone !== mDone || rxDetected !== mRx ||
                txEidle !== 1'b1 || powerDown !== 3'b010) begin
                nMismatched++;
                if (errs < 10)
                    $display("FAIL random_cycle%0d: state=%0d tx=%b done=%b rx=%b eidle=%b pd=%b want state=%0d tx=%b done=%b rx=%b eidle=1 pd=010",
                             c, detState, txDet, detectDone, rxDetected, txEidle, powerDown, mSt, mTx, mDone, mRx);
                errs++;
            end
        end
        resetN = 1'b1; start = 1'b0; phyStatus = 1'b0; rxElecIdle = 1'b1;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_success();
        test_not_detected();
        test_phy_silent();
        test_abort();
        test_reset_mid();
        test_early_exit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/pipe_detect_ctrl.md
# pipe_detect_ctrl

Upstream-port Detect sub-state controller for the Gen1 x1 PIPE link. It sits between the top-level LTSSM and the PIPE `upstream` modport. When the LTSSM enters `detect`, it runs Detect.Quiet → Detect.Active → exit per `pipe_pkg::detect_sub`. It drives the PHY receiver-detection handshake and reports to the LTSSM whether a far-end termination exists, so the LTSSM can advance to `polling`.

## Interface
- `QUIET_TMO`, default `pipe_pkg::timout_12ms` (1200000): Detect.Quiet dwell, in pclk cycles; legal range ≥2.
- `PHY_TMO`, default 64: maximum cycles to wait for PhyStatus in Detect.Active; legal range ≥2.
- `pclk` input 1: sole clock, 100 MHz.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: level from LTSSM, high while LTSSM state == `detect`.
- `PhyStatus` input 1: PIPE PHY completion pulse.
- `RxStatus` input 3: PIPE status; 3'b011 = receiver detected; all other values = not detected.
- `RxElecIdle` input 1: PIPE receiver electrical-idle indication.
- `TxDetectRxorLpbk` output 1: PIPE receiver-detect request.
- `TxElecIdle` output 1: PIPE transmitter electrical idle.
- `PowerDown` output 3: PIPE power state, `power_states` zero-extended.
- `det_state` output 3: current `detect_sub` encoding (idle=0, detect_quiet=1, detect_active=2, exit_detect=3).
- `detect_done` output 1: one-cycle pulse when a receiver is found.
- `rx_detected` output 1: sticky "receiver found" flag.

## Operation
- All outputs are registered. Reset values: `det_state`=idle, `TxDetectRxorLpbk`=0, `TxElecIdle`=1, `PowerDown`=3'b010 (P1), `detect_done`=0, `rx_detected`=0, timers=0.
- `TxElecIdle`=1 and `PowerDown`=P1 in every state; the LTSSM owns power changes after detect.
- **idle:** `start`=1 → detect_quiet, quiet timer cleared, `rx_detected` cleared.
- **detect_quiet:** the quiet timer increments each cycle. At timer == `QUIET_TMO`-1 → detect_active. Timer width is `$clog2(QUIET_TMO)` bits; it saturates and never wraps.
- **detect_active:**
  - `TxDetectRxorLpbk`=1 from the first active cycle through the cycle in which `PhyStatus`=1 is sampled.
  - A separate PHY timer counts active cycles.
  - `PhyStatus`=1 with `RxStatus`==3'b011 → exit_detect, `rx_detected`←1.
  - `PhyStatus`=1 with any other `RxStatus` → detect_quiet (quiet timer cleared).
  - PHY timer reaches `PHY_TMO`-1 with no `PhyStatus` → detect_quiet. This counts as not detected.
- **exit_detect:** `detect_done`=1 for exactly this one cycle, then → idle. `rx_detected` holds 1 until the next idle→detect_quiet transition.
- **Abort:** `start`=0 in any non-idle state → idle next cycle and `TxDetectRxorLpbk`←0. No `detect_done`. `rx_detected` is retained.
- **Simultaneous events:** abort outranks `PhyStatus`. `PhyStatus` outranks PHY timeout in the same cycle. `PhyStatus` outside detect_active is ignored.
- **Reset mid-operation:** any state returns to reset values at the next edge, including the withdrawal of `TxDetectRxorLpbk`.

## Timing
- `start` sampled high at edge N → `det_state`=detect_quiet after edge N.
- Detect.Quiet lasts exactly `QUIET_TMO` cycles; `det_state`=detect_active in the next cycle.
- `TxDetectRxorLpbk` rises in the same cycle `det_state` becomes detect_active.
- `PhyStatus` sampled at edge M → `TxDetectRxorLpbk`=0 and the new state are visible after edge M. On success, `detect_done`=1 in the cycle after M.
- PHY timeout: detect_active lasts exactly `PHY_TMO` cycles when no `PhyStatus` arrives.
- Failed detect loops back to Detect.Quiet indefinitely while `start`=1.

## Configuration
- `DETECT_EIDLE_EXIT_EN` defined: in detect_quiet, `RxElecIdle` sampled 0 moves to detect_active next cycle regardless of the quiet timer. Timer expiry still applies.
- `DETECT_EIDLE_EXIT_EN` undefined: `RxElecIdle` is ignored and Detect.Quiet always lasts the full `QUIET_TMO`.

## Test plan
All scenarios use `QUIET_TMO`=16 and `PHY_TMO`=8.
- **Success:** `start`=1; after 16 quiet cycles, `TxDetectRxorLpbk`=1. Drive `PhyStatus`=1 with `RxStatus`=3'b011 on the 3rd active cycle → `detect_done` one-cycle pulse, `rx_detected`=1, `det_state` returns to 0.
- **Not detected:** as above but with `RxStatus`=3'b000 → `det_state`=1, quiet repeats 16 cycles, `TxDetectRxorLpbk` reasserts, `detect_done` stays 0.
- **PHY silent:** no `PhyStatus` → `TxDetectRxorLpbk` high exactly 8 cycles, then `det_state`=1.
- **Abort:** drop `start` in the same cycle as `PhyStatus`=1/3'b011 → `det_state`=0, no `detect_done`, `rx_detected`=0.
- **Reset:** assert `reset_n`=0 while `TxDetectRxorLpbk`=1 → all outputs take reset values after one edge, including `PowerDown`=3'b010 and `TxElecIdle`=1.
- **Early exit:** with `DETECT_EIDLE_EXIT_EN` defined, `RxElecIdle`=0 on quiet cycle 5 → detect_active from cycle 6. Without the macro → detect_active after 16 cycles.
